store_align: RTL and testbench
==============================

STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port st_valid  input  1  store request present.
REQ-005 SHALL have port st_ready  output  1  block can accept a request.
REQ-006 SHALL have port st_addr  input  AWIDTH  byte address of store.
REQ-007 SHALL have port st_data  input  32  store data, LSB-justified.
REQ-008 SHALL have port st_func3  input  3  000=SB, 001=SH, 010=SW.
REQ-009 SHALL have port mem_valid  output  1  memory write beat present.
REQ-010 SHALL have port mem_ready  input  1  memory accepts beat.
REQ-011 SHALL have port mem_addr  output  AWIDTH  word address, bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port mem_wbe  output  4  byte write enables, bit i = byte lane i.
REQ-014 SHALL have port misalign_err  output  1  one-cycle misaligned-store pulse.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1; st_ready = 1 only in IDLE.
REQ-016 SHALL capture addr/data/func3 on st_valid && st_ready; mem_valid asserts the following cycle (latency 1).
REQ-017 SHALL hold mem_addr, mem_wdata, mem_wbe stable while mem_valid && !mem_ready.
REQ-018 SHALL, on mem_valid && mem_ready in BEAT0, go to BEAT1 if split else IDLE; in BEAT1, go to IDLE.
REQ-019 SHALL, with off = st_addr[1:0], encode SB as wbe = 1<<off, wdata = data[7:0] replicated in all four lanes.
REQ-020 SHALL encode SH off 0/1/2 in one beat: wbe 0011/0110/1100, data[15:0] shifted left by 8*off.
REQ-021 SHALL encode SW off 0 in one beat: wbe 1111, wdata = data.
REQ-022 SHALL split SH off 3 and SW off k!=0 (split enabled): beat0 at word addr, wbe = (1111<<k)[3:0], wdata = data<<8k; beat1 at word addr+4, wbe = 1111>>(4-k), wdata = data>>8(4-k) (SH uses k=3 with 2-byte mask truncation: beat0 1000, beat1 0001).
REQ-023 SHALL compute beat1 address modulo 2^AWIDTH (0xFFFFFFFC wraps to 0x00000000).
REQ-024 SHALL accept func3 outside {000,001,010}, issue no beat, raise no error, remain in IDLE.
REQ-025 SHALL drive mem_wbe = 0000 and mem_wdata = 0 whenever mem_valid = 0.

Reset
REQ-026 SHALL, while rst = 1, force state IDLE, st_ready = 0, mem_valid = 0, mem_addr = 0, mem_wdata = 0, mem_wbe = 0, misalign_err = 0 immediately.
REQ-027 SHALL abandon any in-flight beat on rst mid-operation; no beat resumes after release.
REQ-028 SHALL assert st_ready in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL use macro STORE_MISALIGN_SPLIT_EN to select misaligned handling.
REQ-030 SHALL, with STORE_MISALIGN_SPLIT_EN defined, handle all offsets per REQ-020..REQ-022; misalign_err is tied 0.
REQ-031 SHALL, without STORE_MISALIGN_SPLIT_EN, treat SH off 1/3 and SW off !=0 as misaligned: accepted, no beat issued, misalign_err = 1 for exactly the cycle after accept, FSM stays IDLE; BEAT1 unreachable.

Verification
REQ-032 SB addr 0x00000102 data 0x000000A5, mem_ready=1 -> one beat: addr 0x00000100, wbe 0100, wdata 0xA5A5A5A5, one cycle after accept.
REQ-033 SH addr 0x00000006 data 0x0000BEEF, mem_ready low 3 cycles -> addr 0x00000004, wbe 1100, wdata 0xBEEF0000 held stable 4 cycles.
REQ-034 SW addr 0x00000011 data 0x11223344 (split on) -> beat0 addr 0x10 wbe 1110 wdata 0x22334400; beat1 addr 0x14 wbe 0001 wdata 0x00000011.
REQ-035 SW addr 0xFFFFFFFE data 0xAABBCCDD (split on) -> beat0 addr 0xFFFFFFFC wbe 1100 wdata 0xCCDD0000; beat1 addr 0x00000000 wbe 0011 wdata 0x0000AABB.
REQ-036 SH addr 0x00000003 (split off) -> no mem_valid, misalign_err one-cycle pulse, st_ready remains 1.
REQ-037 rst pulsed while BEAT1 pending with mem_ready=0 -> mem_valid drops same cycle, no beat after release, st_ready=1 next cycle.

Source files
------------

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module      : store_align
// Description : Aligns RISC-V SB/SH/SW stores onto a 32-bit word-addressed
//               write port with byte enables. Crossing stores become two beats
//               when STORE_MISALIGN_SPLIT_EN is defined. Otherwise they are
//               dropped and flagged with a one-cycle misalign_err pulse.
// Revision    : 1.0  initial release
// ============================================================================
module store_align #(
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [AWIDTH-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_func3,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wbe,
    output logic              misalign_err
);

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam logic C_SPLIT_EN = 1'b1;
`else
    localparam logic C_SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    localparam logic [2:0] C_F3_SB = 3'b000;
    localparam logic [2:0] C_F3_SH = 3'b001;
    localparam logic [2:0] C_F3_SW = 3'b010;

    localparam logic [AWIDTH-1:0] C_WORD_STEP = {{(AWIDTH-3){1'b0}}, 3'b100};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [AWIDTH-1:0] r_word_addr;
    logic [3:0]        r_wbe0;
    logic [3:0]        r_wbe1;
    logic [31:0]       r_wdata0;
    logic [31:0]       r_wdata1;
    logic              r_split;
    logic              r_misalign;

    logic              w_accept;
    logic [1:0]        w_off;
    logic [3:0]        w_mask;
    logic [31:0]       w_ext;
    logic [7:0]        w_mask_wide;
    logic [63:0]       w_data_wide;
    logic              w_known;
    logic              w_misalign;
    logic              w_issue;
    logic              w_split;
    logic [3:0]        w_wbe0;
    logic [3:0]        w_wbe1;
    logic [31:0]       w_wdata0;
    logic [31:0]       w_wdata1;

    assign st_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = st_valid && st_ready;
    assign w_off    = st_addr[1:0];

    // Store is laid out across an 8-lane (two-word) window; the upper four
    // lanes are the second beat when the access crosses a word boundary.
    always_comb begin
        w_mask     = 4'b0000;
        w_ext      = 32'h0;
        w_known    = 1'b0;
        w_misalign = 1'b0;
        case (st_func3)
            C_F3_SB: begin
                w_mask  = 4'b0001;
                w_ext   = {24'h0, st_data[7:0]};
                w_known = 1'b1;
            end
            C_F3_SH: begin
                w_mask     = 4'b0011;
                w_ext      = {16'h0, st_data[15:0]};
                w_known    = 1'b1;
                w_misalign = !C_SPLIT_EN && w_off[0];
            end
            C_F3_SW: begin
                w_mask     = 4'b1111;
                w_ext      = st_data;
                w_known    = 1'b1;
                w_misalign = !C_SPLIT_EN && (w_off != 2'b00);
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    assign w_mask_wide = {4'b0000, w_mask} << w_off;
    assign w_data_wide = {32'h0, w_ext} << {w_off, 3'b000};
    assign w_issue     = w_known && !w_misalign;
    assign w_split     = C_SPLIT_EN && (w_mask_wide[7:4] != 4'b0000);
    assign w_wbe0      = w_mask_wide[3:0];
    assign w_wbe1      = w_mask_wide[7:4];
    assign w_wdata0    = (st_func3 == C_F3_SB) ? {4{st_data[7:0]}} : w_data_wide[31:0];
    assign w_wdata1    = w_data_wide[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_wbe0      <= 4'b0000;
            r_wbe1      <= 4'b0000;
            r_wdata0    <= 32'h0;
            r_wdata1    <= 32'h0;
            r_split     <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_misalign <= w_accept && w_misalign;
            if (w_accept) begin
                r_word_addr <= {st_addr[AWIDTH-1:2], 2'b00};
                r_wbe0      <= w_wbe0;
                r_wbe1      <= w_wbe1;
                r_wdata0    <= w_wdata0;
                r_wdata1    <= w_wdata1;
                r_split     <= w_split;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_issue) w_next_state = ST_BEAT0;
            ST_BEAT0: if (mem_ready) w_next_state = r_split ? ST_BEAT1 : ST_IDLE;
            ST_BEAT1: if (mem_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are zero outside a beat so idle cycles never carry stale lanes.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wbe   = 4'b0000;
        mem_wdata = 32'h0;
        case (r_state)
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = r_word_addr;
                mem_wbe   = r_wbe0;
                mem_wdata = r_wdata0;
            end
            ST_BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = r_word_addr + C_WORD_STEP;
                mem_wbe   = r_wbe1;
                mem_wdata = r_wdata1;
            end
            default: begin
                mem_valid = 1'b0;
            end
        endcase
    end

    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_store_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_align
// Description : Self-checking bench for store_align against a byte-level
//               reference model (honours STORE_MISALIGN_SPLIT_EN).
// Revision    : 1.0  initial release
// ============================================================================
module tb_store_align;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_func3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;
    logic        misalign_err;

    store_align #(.AWIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_func3     (st_func3),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wbe      (mem_wbe),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wbe;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    exp_err;
    int    obs_err;
    int    obs_valid_cycles;
    bit    obs_first_valid;
    bit    obs_timeout;
    bit    obs_idle_bad;
    bit    obs_hold_bad;
    bit    obs_not_ready;
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference: walk the store byte by byte, place each byte in its word/lane.
    function automatic void build_expect(input logic [31:0] a, input logic [31:0] d,
                                         input logic [2:0] f);
        int          size;
        int          nb;
        int          idx;
        beat_t       b [2];
        logic [31:0] ba;
        logic [31:0] w;
        exp_q.delete();
        exp_err = 0;
        case (f)
            3'd0:    size = 1;
            3'd1:    size = 2;
            3'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) return;
        if (!SPLIT && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00))) begin
            exp_err = 1;
            return;
        end
        b[0] = '0;
        b[1] = '0;
        b[0].addr = a & 32'hFFFF_FFFC;
        b[1].addr = b[0].addr + 32'd4;
        nb = 1;
        for (int i = 0; i < size; i++) begin
            ba  = a + i;
            w   = ba & 32'hFFFF_FFFC;
            idx = (w == b[0].addr) ? 0 : 1;
            if (idx == 1) nb = 2;
            b[idx].wbe[ba[1:0]] = 1'b1;
            b[idx].wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
        end
        if (size == 1) b[0].wdata = {4{d[7:0]}};
        for (int k = 0; k < nb; k++) exp_q.push_back(b[k]);
    endfunction

    // Drives one store from a negedge and records what the memory side shows.
    // stall < 0: random 0..2 wait cycles per beat; otherwise first beat waits 'stall'.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f, input int stall);
        int    left;
        beat_t held;
        bit    holding;
        obs_q.delete();
        obs_err          = 0;
        obs_valid_cycles = 0;
        obs_timeout      = 1'b1;
        obs_idle_bad     = 1'b0;
        obs_hold_bad     = 1'b0;
        holding          = 1'b0;
        held             = '0;
        obs_not_ready    = !st_ready;
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_func3  = f;
        mem_ready = 1'b0;
        @(negedge clk);
        st_valid  = 1'b0;
        st_addr   = $urandom;
        st_data   = $urandom;
        st_func3  = 3'($urandom_range(7, 0));
        obs_first_valid = mem_valid;
        left = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
        for (int c = 0; c < 64; c++) begin
            if (misalign_err) obs_err++;
            if (!mem_valid) begin
                if (mem_wbe !== 4'b0000 || mem_wdata !== 32'h0) obs_idle_bad = 1'b1;
                if (holding) obs_hold_bad = 1'b1;
                if (st_ready) begin
                    obs_timeout = 1'b0;
                    break;
                end
            end else begin
                obs_valid_cycles++;
                if (holding && {mem_addr, mem_wbe, mem_wdata} !== held) obs_hold_bad = 1'b1;
                if (left == 0) begin
                    mem_ready = 1'b1;
                    obs_q.push_back({mem_addr, mem_wbe, mem_wdata});
                    holding = 1'b0;
                    left = (stall < 0) ? int'($urandom_range(2, 0)) : 0;
                end else begin
                    mem_ready = 1'b0;
                    left--;
                    holding = 1'b1;
                    held = {mem_addr, mem_wbe, mem_wdata};
                end
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        if (misalign_err) obs_err++;
    endtask

    task automatic test_reset();
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_func3 = '0; mem_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if ({st_ready, mem_valid, misalign_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {st_ready, mem_valid, misalign_err});
        end
        n_checks++;
        if ({mem_addr, mem_wbe, mem_wdata} !== 68'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wbe, mem_wdata});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (st_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", st_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_sb_directed();
        run_store(32'h0000_0102, 32'h0000_00A5, 3'b000, 0);
        n_checks++;
        if (obs_first_valid !== 1'b1 || obs_q.size() != 1) begin
            n_fail++; $display("FAIL sb_latency: got valid=%b beats=%0d expected valid=1 beats=1", obs_first_valid, obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {32'h0000_0100, 4'b0100, 32'hA5A5_A5A5}) begin
                n_fail++; $display("FAIL sb_beat: got %h expected %h", obs_q[0], {32'h0000_0100, 4'b0100, 32'hA5A5_A5A5});
            end
        end
    endtask

    task automatic test_sh_stall();
        run_store(32'h0000_0006, 32'h0000_BEEF, 3'b001, 3);
        n_checks++;
        if (obs_q.size() != 1 || obs_valid_cycles != 4 || obs_hold_bad) begin
            n_fail++; $display("FAIL sh_stall: got beats=%0d valid_cycles=%0d hold_bad=%b expected 1/4/0", obs_q.size(), obs_valid_cycles, obs_hold_bad);
        end else begin
            n_checks++;
            if (obs_q[0] !== {32'h0000_0004, 4'b1100, 32'hBEEF_0000}) begin
                n_fail++; $display("FAIL sh_beat: got %h expected %h", obs_q[0], {32'h0000_0004, 4'b1100, 32'hBEEF_0000});
            end
        end
    endtask

`ifdef STORE_MISALIGN_SPLIT_EN
    task automatic test_split();
        run_store(32'h0000_0011, 32'h1122_3344, 3'b010, 0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL split_count: got %0d expected 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {32'h10, 4'b1110, 32'h2233_4400} || obs_q[1] !== {32'h14, 4'b0001, 32'h0000_0011}) begin
                n_fail++; $display("FAIL split_beats: got %h %h", obs_q[0], obs_q[1]);
            end
        end
        run_store(32'hFFFF_FFFE, 32'hAABB_CCDD, 3'b010, 1);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000} || obs_q[1] !== {32'h0, 4'b0011, 32'h0000_AABB}) begin
                n_fail++; $display("FAIL wrap_beats: got %h %h", obs_q[0], obs_q[1]);
            end
        end
    endtask
`else
    task automatic test_misalign();
        run_store(32'h0000_0003, 32'h0000_1234, 3'b001, 0);
        n_checks++;
        if (obs_q.size() != 0 || obs_first_valid !== 1'b0 || obs_err != 1 || obs_timeout) begin
            n_fail++; $display("FAIL misalign_pulse: got beats=%0d valid=%b err_cycles=%0d timeout=%b expected 0/0/1/0", obs_q.size(), obs_first_valid, obs_err, obs_timeout);
        end
        n_checks++;
        if (st_ready !== 1'b1) begin
            n_fail++; $display("FAIL misalign_ready: got %b expected 1", st_ready);
        end
    endtask
`endif

    task automatic test_bad_func3();
        for (int f = 3; f < 8; f++) begin
            run_store($urandom, $urandom, 3'(f), 0);
            n_checks++;
            if (obs_q.size() != 0 || obs_err != 0 || obs_timeout || obs_not_ready) begin
                n_fail++; $display("FAIL bad_func3_%0d: got beats=%0d err=%0d timeout=%b expected 0/0/0", f, obs_q.size(), obs_err, obs_timeout);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        st_valid = 1'b1;
        st_data  = 32'hDEAD_BEEF;
        st_func3 = 3'b010;
        st_addr  = SPLIT ? 32'h0000_0011 : 32'h0000_0010;
        mem_ready = 1'b0;
        @(negedge clk);
        st_valid = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
`endif
        n_checks++;
        if (mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pending: got %b expected 1", mem_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid, st_ready, mem_wbe} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_drop: got valid=%b ready=%b wbe=%b addr=%h expected 0", mem_valid, st_ready, mem_wbe, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (st_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b expected 1", st_ready);
        end
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL rstmid_resume: got %0d beat cycles expected 0", stray);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_random(input int n);
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        for (int t = 0; t < n; t++) begin
            case ($urandom_range(2, 0))
                0:       a = $urandom;
                1:       a = 32'hFFFF_FFFC + $urandom_range(3, 0);
                default: a = $urandom_range(31, 0);
            endcase
            d = $urandom;
            f = ($urandom_range(9, 0) < 8) ? 3'($urandom_range(2, 0)) : 3'($urandom_range(7, 3));
            build_expect(a, d, f);
            run_store(a, d, f, -1);
            n_checks++;
            if (obs_timeout || obs_not_ready) begin
                n_fail++; $display("FAIL rnd_handshake[%0d]: timeout=%b not_ready=%b expected 0/0", t, obs_timeout, obs_not_ready);
            end
            n_checks++;
            if (obs_first_valid !== (exp_q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_latency[%0d]: got valid=%b expected %b", t, obs_first_valid, exp_q.size() > 0);
            end
            n_checks++;
            if (obs_err != exp_err) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got %0d expected %0d (a=%h f=%0d)", t, obs_err, exp_err, a, f);
            end
            n_checks++;
            if (obs_idle_bad || obs_hold_bad) begin
                n_fail++; $display("FAIL rnd_stable[%0d]: idle_bad=%b hold_bad=%b expected 0/0", t, obs_idle_bad, obs_hold_bad);
            end
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d (a=%h f=%0d)", t, obs_q.size(), exp_q.size(), a, f);
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_checks++;
                    if (obs_q[k] !== exp_q[k]) begin
                        n_fail++; $display("FAIL rnd_beat[%0d.%0d]: got %h expected %h (a=%h d=%h f=%0d)", t, k, obs_q[k], exp_q[k], a, d, f);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb_directed();
        test_sh_stall();
`ifdef STORE_MISALIGN_SPLIT_EN
        test_split();
`else
        test_misalign();
`endif
        test_bad_func3();
        test_reset_mid();
        test_random(300);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
